// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Fetch sequencer in front of a combinational instruction ROM. It owns the
// program counter, drives the ROM address straight from the PC, and registers
// the returned instruction together with its fetch address and a valid flag
// for the decode stage.
//
// Handshake: instr_o/instr_pc_o are offered whenever instr_valid_o=1. The
// decode stage consumes the word on every rising edge where
// instr_valid_o=1 and stall_i=0. While stall_i=1 every piece of fetch state
// holds, and branch_taken_i is not looked at. A taken branch refers to the
// word currently on instr_o and must be held until it is consumed.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i             leave IDLE and begin fetching
//   stall_i             decode cannot accept; freeze fetch state
//   branch_taken_i      word on instr_o is a taken branch
//   branch_target_i     destination of that branch
//   rom_addr_o          ROM address (equals PC, combinational)
//   rom_data_i          ROM data for rom_addr_o, same cycle
//   instr_o, instr_pc_o registered instruction and its address
//   instr_valid_o       instr_o holds a live instruction
//   halted_o            fetch stopped after HALT_INSTR was consumed
//   busy_o              sequencer is in RUN
//   retired_cnt_o       saturating count of consumed instructions
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int unsigned      ADDR_W     = 8,
    parameter int unsigned      DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
    parameter logic [DATA_W-1:0] HALT_INSTR = 8'hFF,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    output logic              halted_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        // A word is consumed on every unstalled cycle it is valid, in any
        // state; this includes the HALT word itself.
        if (valid_q && !stall_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // The start cycle only changes state; first capture is next.
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (branch_taken_i && valid_q) begin
                        // Squash the fall-through fetch; its data is never
                        // inspected, so a HALT there cannot stop fetch.
                        pc_d    = branch_target_i;
                        valid_d = 1'b0;
                    end else begin
                        instr_d    = rom_data_i;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 1'b1;  // wraps modulo 2^ADDR_W
                        if (rom_data_i == HALT_INSTR) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                // PC stays frozen; the HALT word leaves once it is consumed.
                if (!stall_i) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_ADDR;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign busy_o        = (state_q == ST_RUN);
    assign retired_cnt_o = cnt_q;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the combinational instruction ROM (8-bit address in, 8-bit instruction out).
- Owns the program counter, drives the ROM address and registers the returned instruction with a valid flag for the decode stage.
- Handles start, stall back-pressure, taken branches with squash, HALT detection, and a retired-instruction counter.

Parameters:
- ADDR_W, 8, PC and ROM address width.
- DATA_W, 8, instruction width.
- START_ADDR, 8'h00, PC value loaded by reset.
- HALT_INSTR, 8'hFF, instruction encoding that stops fetch.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  leave IDLE and begin fetching.
- stall_i  in  1  decode cannot accept; hold all fetch state.
- branch_taken_i  in  1  instruction currently on instr_o is a taken branch.
- branch_target_i  in  ADDR_W  target address for branch_taken_i.
- rom_addr_o  out  ADDR_W  address to ROM; equals PC (combinational).
- rom_data_i  in  DATA_W  ROM data for rom_addr_o, same cycle.
- instr_o  out  DATA_W  registered instruction.
- instr_pc_o  out  ADDR_W  address instr_o was fetched from.
- instr_valid_o  out  1  instr_o is valid this cycle.
- halted_o  out  1  fetch stopped by HALT_INSTR.
- busy_o  out  1  state is RUN.
- retired_cnt_o  out  CNT_W  count of consumed instructions.

Behaviour:
- Reset has priority over every other input:
  - state=IDLE, pc=START_ADDR.
  - instr_o=0, instr_pc_o=0, instr_valid_o=0.
  - halted_o=0, busy_o=0, retired_cnt_o=0.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN when start_i=1. No fetch capture occurs in the start cycle.
  - RUN -> HALT on a non-squashed capture of HALT_INSTR.
  - HALT exits only via reset. start_i is ignored in RUN and HALT.
- RUN, stall_i=0, branch_taken_i=0 or instr_valid_o=0:
  - instr_o<=rom_data_i, instr_pc_o<=pc, instr_valid_o<=1, pc<=pc+1.
  - Latency: the PC presented in cycle t appears on instr_o in cycle t+1.
- RUN, stall_i=1: pc, instr_o, instr_pc_o and instr_valid_o hold. branch_taken_i is ignored; the consumer must hold it until stall_i drops.
- RUN, stall_i=0, branch_taken_i=1, instr_valid_o=1:
  - pc<=branch_target_i, instr_valid_o<=0 (squash the fall-through fetch).
  - No HALT detection on the squashed data.
  - Target instruction valid two cycles after the branch cycle (1-bubble penalty).
- branch_taken_i with instr_valid_o=0 is ignored.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 -> 8'h00, no flag.
- HALT:
  - The HALT_INSTR word is presented with instr_valid_o=1 for one cycle, extended while stall_i=1.
  - On the first non-stalled cycle in HALT: instr_valid_o<=0, halted_o<=1. PC is frozen from HALT entry.
  - branch_taken_i is ignored in HALT.
- retired_cnt_o increments on each cycle with instr_valid_o=1 and stall_i=0, including the HALT word. It saturates at all-ones.
- busy_o=1 exactly while state=RUN.
- Reset mid-RUN or mid-stall returns to IDLE next edge with all reset values; no pending branch survives.

Test Plan:
- Bench ROM model: mem[a]=a+8'h10, mem[8'h08]=8'hFF. Reset 2 cycles, start_i pulse -> instr_o=8'h10,8'h11,... with instr_pc_o 0,1,...; HALT word at pc 8 valid one cycle; then halted_o=1, instr_valid_o=0, retired_cnt_o=9.
- stall_i high 3 cycles while instr_o=8'h12 -> instr_o/instr_pc_o/rom_addr_o frozen; sequence resumes at 8'h13 with no skip or duplicate.
- branch_taken_i=1, target 8'h40, while instr_pc_o=8'h02 -> one bubble (valid=0), then instr_pc_o=8'h40, instr_o=8'h50; retired_cnt_o excludes the bubble.
- Branch and stall together, then stall released with the branch held -> the branch is taken exactly once, on release.
- START_ADDR=8'hFE, no halt in ROM -> instr_pc_o FE, FF, 00, 01.
- reset_i asserted mid-RUN and during a squash cycle -> next cycle all outputs at reset values and state IDLE; a new start_i refetches from START_ADDR.
- Branch to 8'h08 (HALT) -> HALT word valid once, then halted_o=1; later start_i and branch_taken_i pulses have no effect.
